// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu opcodes, memory-stage states and writeback decode
package cpu_pkg;

    localparam logic [3:0] ADD_OP  = 4'h0;
    localparam logic [3:0] SUB_OP  = 4'h1;
    localparam logic [3:0] MUL_OP  = 4'h2;
    localparam logic [3:0] DIV_OP  = 4'h3;
    localparam logic [3:0] AND_OP  = 4'h4;
    localparam logic [3:0] OR_OP   = 4'h5;
    localparam logic [3:0] XOR_OP  = 4'h6;
    localparam logic [3:0] ADDI_OP = 4'h7;
    localparam logic [3:0] LW_OP   = 4'h8;
    localparam logic [3:0] SW_OP   = 4'h9;
    localparam logic [3:0] BEQ_OP  = 4'hA;
    localparam logic [3:0] BGT_OP  = 4'hB;
    localparam logic [3:0] BGE_OP  = 4'hC;
    localparam logic [3:0] JMP_OP  = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Register-file write enable for an opcode; shared with the decode stage.
    function automatic logic rf_we(input logic [3:0] op);
        case (op)
            ADD_OP, SUB_OP, MUL_OP, DIV_OP,
            AND_OP, OR_OP, XOR_OP, ADDI_OP, LW_OP: rf_we = 1'b1;
            default:                               rf_we = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: pass-through ALU results, LW/SW to data memory
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int REGW      = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [3:0]           opcode_i,
    input  logic [DATAWIDTH-1:0] alu_result_i,
    input  logic [DATAWIDTH-1:0] store_data_i,
    input  logic [REGW-1:0]      rd_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [DATAWIDTH-1:0] mem_addr_o,
    output logic [DATAWIDTH-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DATAWIDTH-1:0] mem_rdata_i,
    output logic                 wb_valid_o,
    output logic                 wb_we_o,
    output logic [REGW-1:0]      wb_rd_o,
    output logic [DATAWIDTH-1:0] wb_data_o,
    output logic                 misalign_o
);

    mem_state_t             r_state;
    mem_state_t             w_next_state;
    logic [DATAWIDTH-1:0]   r_addr;
    logic [DATAWIDTH-1:0]   r_wdata;
    logic [REGW-1:0]        r_rd;
    logic                   r_mem_we;
    logic                   r_wb_valid;
    logic                   r_wb_we;
    logic [REGW-1:0]        r_wb_rd;
    logic [DATAWIDTH-1:0]   r_wb_data;
    logic                   r_misalign;

    logic w_accept;
    logic w_is_mem;
    logic w_misaligned;

    assign w_accept     = valid_i && (r_state == IDLE);
    assign w_is_mem     = (opcode_i == LW_OP) || (opcode_i == SW_OP);
    assign w_misaligned = (alu_result_i[1:0] != 2'b00);

    assign ready_o     = (r_state == IDLE);
    assign mem_req_o   = (r_state == REQ);
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign wb_valid_o  = r_wb_valid;
    assign wb_we_o     = r_wb_we;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign misalign_o  = r_misalign;

    // State register; reset abandons any outstanding memory transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: aligned LW/SW go to memory, stores finish on grant, loads wait for rvalid.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mem && !w_misaligned) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    w_next_state = r_mem_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request latches and registered writeback; wb fields hold when no pulse is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_mem_we   <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem && w_misaligned) begin
                            r_wb_valid <= 1'b1;
                            r_misalign <= 1'b1;
                            r_wb_we    <= 1'b0;
                            r_wb_rd    <= rd_i;
                            r_wb_data  <= alu_result_i;
                        end else if (w_is_mem) begin
                            r_addr   <= alu_result_i;
                            r_wdata  <= store_data_i;
                            r_rd     <= rd_i;
                            r_mem_we <= (opcode_i == SW_OP);
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= rf_we(opcode_i);
                            r_wb_rd    <= rd_i;
                            r_wb_data  <= alu_result_i;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i && r_mem_we) begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= 1'b0;
                        r_wb_rd    <= r_rd;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  opcode_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    typedef struct {
        logic        we;
        logic        mis;
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mem_stage #(.DATAWIDTH(32), .REGW(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .opcode_i     (opcode_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .rd_i         (rd_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic we, input logic mis, input logic chk,
                        input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.we = we; e.mis = mis; e.chk_data = chk; e.rd = rd; e.data = data;
        sb.push_back(e);
    endtask

    // Scoreboard: every writeback pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (wb_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_wb_valid", 32'(wb_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_wb_we", 32'(wb_we_o), 32'(e.we));
                check("sb_misalign", 32'(misalign_o), 32'(e.mis));
                if (e.chk_data) begin
                    check("sb_wb_rd", 32'(wb_rd_o), 32'(e.rd));
                    check("sb_wb_data", wb_data_o, e.data);
                end
            end
        end else if (misalign_o) begin
            check("misalign_without_wb", 32'(misalign_o), 32'd0);
        end
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; opcode_i = ADD_OP; alu_result_i = '0;
        store_data_i = '0; rd_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        tick(); tick();
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_we", 32'(wb_we_o), 32'd0);
        check("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // ADD: latency-1 writeback, no memory request
        valid_i = 1'b1; opcode_i = ADD_OP; alu_result_i = 32'h5; rd_i = 5'd3;
        push(1'b1, 1'b0, 1'b1, 5'd3, 32'h5);
        check("add_no_req_pre", 32'(mem_req_o), 32'd0);
        tick();
        valid_i = 1'b0;
        check("add_wb_valid", 32'(wb_valid_o), 32'd1);
        check("add_wb_data", wb_data_o, 32'h5);
        check("add_no_req", 32'(mem_req_o), 32'd0);
        tick();
        check("add_pulse_end", 32'(wb_valid_o), 32'd0);
        check("add_no_req_post", 32'(mem_req_o), 32'd0);

        // LW 0x100: grant after 2 waiting cycles, rvalid 3 cycles after grant
        valid_i = 1'b1; opcode_i = LW_OP; alu_result_i = 32'h100; rd_i = 5'd7;
        tick();
        valid_i = 1'b0; alu_result_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check("lw_req", 32'(mem_req_o), 32'd1);
            check("lw_addr", mem_addr_o, 32'h100);
            check("lw_we", 32'(mem_we_o), 32'd0);
            check("lw_ready_req", 32'(ready_o), 32'd0);
            tick();
        end
        check("lw_req_at_gnt", 32'(mem_req_o), 32'd1);
        check("lw_addr_at_gnt", mem_addr_o, 32'h100);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("lw_wait_req", 32'(mem_req_o), 32'd0);
            check("lw_ready_wait", 32'(ready_o), 32'd0);
            check("lw_wait_nowb", 32'(wb_valid_o), 32'd0);
            tick();
        end
        check("lw_ready_wait_last", 32'(ready_o), 32'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        push(1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        check("lw_wb_valid", 32'(wb_valid_o), 32'd1);
        check("lw_ready_after", 32'(ready_o), 32'd1);
        tick();
        check("lw_pulse_end", 32'(wb_valid_o), 32'd0);

        // SW 0x20 with immediate grant
        valid_i = 1'b1; opcode_i = SW_OP; alu_result_i = 32'h20;
        store_data_i = 32'h1234; rd_i = 5'd2;
        tick();
        valid_i = 1'b0; store_data_i = 32'h0;
        check("sw_req", 32'(mem_req_o), 32'd1);
        check("sw_we", 32'(mem_we_o), 32'd1);
        check("sw_addr", mem_addr_o, 32'h20);
        check("sw_wdata", mem_wdata_o, 32'h1234);
        check("sw_ready_req", 32'(ready_o), 32'd0);
        mem_gnt_i = 1'b1;
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        mem_gnt_i = 1'b0;
        check("sw_wb_valid", 32'(wb_valid_o), 32'd1);
        check("sw_ready_after", 32'(ready_o), 32'd1);
        check("sw_req_drop", 32'(mem_req_o), 32'd0);
        tick();
        check("sw_pulse_end", 32'(wb_valid_o), 32'd0);

        // misaligned LW 0x102
        valid_i = 1'b1; opcode_i = LW_OP; alu_result_i = 32'h102; rd_i = 5'd9;
        push(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        valid_i = 1'b0;
        check("mis_no_req", 32'(mem_req_o), 32'd0);
        check("mis_flag", 32'(misalign_o), 32'd1);
        check("mis_wb_valid", 32'(wb_valid_o), 32'd1);
        check("mis_ready", 32'(ready_o), 32'd1);
        tick();
        check("mis_flag_end", 32'(misalign_o), 32'd0);
        check("mis_wb_end", 32'(wb_valid_o), 32'd0);
        check("mis_no_req_after", 32'(mem_req_o), 32'd0);

        // reset while in WAIT, then a stray rvalid
        valid_i = 1'b1; opcode_i = LW_OP; alu_result_i = 32'h40; rd_i = 5'd5;
        tick();
        valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("rw_in_wait", 32'(ready_o), 32'd0);
        rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        tick();
        rst_i = 1'b0;
        check("rw_ready", 32'(ready_o), 32'd1);
        check("rw_no_wb", 32'(wb_valid_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        check("rw_stray_no_wb", 32'(wb_valid_o), 32'd0);
        check("rw_ready2", 32'(ready_o), 32'd1);
        check("rw_no_req", 32'(mem_req_o), 32'd0);

        // reset has priority over valid in the same cycle
        rst_i = 1'b1; valid_i = 1'b1; opcode_i = ADD_OP; alu_result_i = 32'h77;
        tick();
        rst_i = 1'b0; valid_i = 1'b0;
        check("rp_no_wb", 32'(wb_valid_o), 32'd0);
        check("rp_data_zero", wb_data_o, 32'd0);

        // back-to-back ADD, BEQ, XOR, then an unknown opcode
        valid_i = 1'b1; opcode_i = ADD_OP; alu_result_i = 32'h11; rd_i = 5'd1;
        push(1'b1, 1'b0, 1'b1, 5'd1, 32'h11);
        tick();
        check("b2b_add_v", 32'(wb_valid_o), 32'd1);
        check("b2b_add_we", 32'(wb_we_o), 32'd1);
        opcode_i = BEQ_OP; alu_result_i = 32'h22; rd_i = 5'd2;
        push(1'b0, 1'b0, 1'b1, 5'd2, 32'h22);
        tick();
        check("b2b_beq_v", 32'(wb_valid_o), 32'd1);
        check("b2b_beq_we", 32'(wb_we_o), 32'd0);
        opcode_i = XOR_OP; alu_result_i = 32'h33; rd_i = 5'd4;
        push(1'b1, 1'b0, 1'b1, 5'd4, 32'h33);
        tick();
        check("b2b_xor_v", 32'(wb_valid_o), 32'd1);
        check("b2b_xor_we", 32'(wb_we_o), 32'd1);
        opcode_i = 4'hF; alu_result_i = 32'h44; rd_i = 5'd6;
        push(1'b0, 1'b0, 1'b1, 5'd6, 32'h44);
        tick();
        valid_i = 1'b0;
        check("unk_we", 32'(wb_we_o), 32'd0);
        tick();
        check("b2b_end", 32'(wb_valid_o), 32'd0);
        check("b2b_hold_rd", 32'(wb_rd_o), 32'd6);
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
